// File: rtl/uart_driver_pkg.sv
// Shared constants, FSM state type and byte-select helper for the UART sample driver.
package uart_driver_pkg;

  localparam int DATA_W         = 22;
  localparam int BYTES_PER_WORD = 3;
  localparam int BITS_PER_BYTE  = 8;
  localparam int FRAME_W        = BYTES_PER_WORD * BITS_PER_BYTE;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Byte b of a sample, least significant first; the top byte is zero-padded.
  function automatic logic [BITS_PER_BYTE-1:0] word_byte(input logic [DATA_W-1:0] w,
                                                          input logic [1:0]        b);
    logic [FRAME_W-1:0] padded;
    padded = {{(FRAME_W-DATA_W){1'b0}}, w};
    case (b)
      2'd0:    word_byte = padded[7:0];
      2'd1:    word_byte = padded[15:8];
      default: word_byte = padded[23:16];
    endcase
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO holding samples awaiting transmission.
module sample_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = uart_driver_pkg::DATA_W
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by the pointers and count alone.
  always_ff @(posedge sys_clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_driver.sv
// Buffers 22-bit samples and serialises each as three 8N1 bytes paced by an external bit strobe.
module uart_driver
  import uart_driver_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              sys_clock,
  input  logic              reset,
  output logic              UART_TX,
  input  logic              UART_send,
  input  logic              new_frame,
  input  logic [DATA_W-1:0] i_data
);

  logic                     send_d;
  logic                     tick;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [DATA_W-1:0]        fifo_dout;
  tx_state_e                state;
  logic [1:0]               byte_idx;
  logic [2:0]               bit_idx;
  logic [DATA_W-1:0]        shift_word;
  logic [BITS_PER_BYTE-1:0] cur_byte;
  logic                     last_byte;

  assign tick      = UART_send & ~send_d;
  assign cur_byte  = word_byte(shift_word, byte_idx);
  assign last_byte = (byte_idx == 2'(BYTES_PER_WORD-1));
  assign fifo_pop  = tick & ~fifo_empty & ((state == IDLE) | ((state == STOP) & last_byte));
  assign fifo_push = new_frame & (~fifo_full | fifo_pop);

  sample_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .sys_clock (sys_clock),
    .reset     (reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .din       (i_data),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: all state here is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      send_d     <= 1'b1;
      state      <= IDLE;
      UART_TX    <= 1'b1;
      byte_idx   <= '0;
      bit_idx    <= '0;
      shift_word <= '0;
    end else begin
      send_d <= UART_send;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!fifo_empty) begin
              shift_word <= fifo_dout;
              byte_idx   <= '0;
              UART_TX    <= 1'b0;
              state      <= START;
            end
          end
          START: begin
            UART_TX <= cur_byte[0];
            bit_idx <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_idx == 3'(BITS_PER_BYTE-1)) begin
              UART_TX <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              UART_TX <= cur_byte[3'(bit_idx + 3'd1)];
            end
          end
          STOP: begin
            if (!last_byte) begin
              byte_idx <= byte_idx + 2'd1;
              UART_TX  <= 1'b0;
              state    <= START;
            end else if (!fifo_empty) begin
              // Next word starts straight from the stop bit, no idle gap.
              shift_word <= fifo_dout;
              byte_idx   <= '0;
              UART_TX    <= 1'b0;
              state      <= START;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_driver.sv
// Scoreboard bench for uart_driver: stimulus queues expected words, a UART receiver checks the line.
module tb_uart_driver;

  logic        sys_clock;
  logic        reset;
  logic        UART_TX;
  logic        UART_send;
  logic        new_frame;
  logic [21:0] i_data;

  logic [7:0]  div;
  int          per;
  logic        send_mode;
  logic        send_force;

  logic [21:0] sb[$];
  int          n_checks;
  int          n_fail;

  logic        rx_busy;
  int          rx_cnt;
  int          rx_nb;
  logic [7:0]  rx_byte;
  logic [23:0] rx_word;

  uart_driver #(.DEPTH(16)) dut (
    .sys_clock (sys_clock),
    .reset     (reset),
    .UART_TX   (UART_TX),
    .UART_send (UART_send),
    .new_frame (new_frame),
    .i_data    (i_data)
  );

  assign UART_send = send_mode ? ((int'(div) % per) >= (per / 2)) : send_force;

  initial begin
    sys_clock = 1'b0;
    forever #5 sys_clock = ~sys_clock;
  end

  initial begin
    div = '0;
    forever begin
      @(negedge sys_clock);
      div = div + 8'd1;
    end
  end

  initial begin
    #(900000);
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // UART receiver: samples each bit in the middle of its period.
  initial begin
    int k;
    rx_busy = 1'b0;
    rx_cnt  = 0;
    rx_nb   = 0;
    rx_byte = '0;
    rx_word = '0;
    forever begin
      @(negedge sys_clock);
      if (reset) begin
        rx_busy = 1'b0;
        rx_nb   = 0;
        rx_cnt  = 0;
      end else if (!rx_busy) begin
        if (UART_TX === 1'b0) begin
          rx_busy = 1'b1;
          rx_cnt  = 0;
        end
      end else begin
        rx_cnt++;
        if ((rx_cnt % per) == (per / 2)) begin
          k = rx_cnt / per;
          if (k == 0) begin
            check("start_bit", {23'd0, UART_TX}, 24'd0);
          end else if (k <= 8) begin
            rx_byte[k-1] = UART_TX;
          end else begin
            check("stop_bit", {23'd0, UART_TX}, 24'd1);
            rx_word[8*rx_nb +: 8] = rx_byte;
            rx_nb++;
            rx_busy = 1'b0;
            if (rx_nb == 3) begin
              rx_nb = 0;
              if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word actual=%h required=none", rx_word);
              end else begin
                check("word", rx_word, {2'b00, sb.pop_front()});
              end
            end
          end
        end
      end
    end
  end

  // Returns at negedge+1 just before the n-th upcoming tick edge.
  task automatic wait_pre_tick(input int n);
    int k = 0;
    while (k < n) begin
      @(negedge sys_clock);
      #1;
      if ((int'(div) % per) == (per / 2)) k++;
    end
  endtask

  task automatic step();
    @(negedge sys_clock);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while ((sb.size() != 0 || rx_busy || rx_nb != 0) && c < budget) begin
      step();
      c++;
    end
    check("drain_pending", 24'(sb.size()), 24'd0);
    repeat (2 * per) step();
    check("idle_high", {23'd0, UART_TX}, 24'd1);
  endtask

  initial begin
    logic saw_low;
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    new_frame  = 1'b0;
    i_data     = '0;
    per        = 128;
    send_mode  = 1'b0;
    send_force = 1'b1;

    // Reset with strobe held high, then single word at period 128.
    repeat (3) @(negedge sys_clock);
    #1 reset = 1'b0;
    step();
    check("reset_tx", {23'd0, UART_TX}, 24'd1);
    new_frame = 1'b1;
    i_data    = 22'h0f0f0f;
    sb.push_back(22'h0f0f0f);
    step();
    new_frame = 1'b0;
    repeat (300) step();
    check("no_tick_while_high", {23'd0, UART_TX}, 24'd1);
    while ((int'(div) % per) != 100) step();
    send_mode = 1'b1;
    wait_drain(31 * 128 + 600);

    // Overfill: 20 consecutive writes, only the first 16 fit.
    per = 32;
    wait_pre_tick(1);
    step();
    for (int i = 0; i < 20; i++) begin
      new_frame = 1'b1;
      i_data    = 22'(i);
      if (i < 16) sb.push_back(22'(i));
      step();
    end
    new_frame = 1'b0;
    wait_drain(17 * 30 * 32);

    // Full FIFO with a simultaneous push and pop.
    wait_pre_tick(1);
    step();
    for (int i = 0; i < 16; i++) begin
      new_frame = 1'b1;
      i_data    = 22'h100000 + 22'(i);
      sb.push_back(22'h100000 + 22'(i));
      step();
    end
    new_frame = 1'b0;
    wait_pre_tick(1);
    step();
    new_frame = 1'b1;
    i_data    = 22'h2aaaaa;
    sb.push_back(22'h2aaaaa);
    step();
    new_frame = 1'b0;
    wait_pre_tick(30);
    new_frame = 1'b1;
    i_data    = 22'h3fffff;
    sb.push_back(22'h3fffff);
    step();
    new_frame = 1'b0;
    wait_drain(19 * 30 * 32);

    // Reset during DATA of byte1; both queued words are abandoned.
    wait_pre_tick(1);
    step();
    new_frame = 1'b1;
    i_data    = 22'h123456;
    step();
    i_data    = 22'h0abcde;
    step();
    new_frame = 1'b0;
    wait_pre_tick(1);
    wait_pre_tick(13);
    repeat (5) step();
    reset = 1'b1;
    step();
    check("reset_mid_tx", {23'd0, UART_TX}, 24'd1);
    reset   = 1'b0;
    saw_low = 1'b0;
    repeat (40 * per) begin
      step();
      if (UART_TX !== 1'b1) saw_low = 1'b1;
    end
    check("no_start_after_reset", {23'd0, saw_low}, 24'd0);

    // Refill: write one cycle before a tick -> start bit on that tick.
    while ((int'(div) % per) != (per / 2 - 1)) step();
    new_frame = 1'b1;
    i_data    = 22'h2c3a5e;
    sb.push_back(22'h2c3a5e);
    step();
    new_frame = 1'b0;
    step();
    check("start_first_tick", {23'd0, UART_TX}, 24'd0);
    wait_drain(31 * 32 + 200);

    // Push on the tick edge with FIFO empty: stored, sent on the next tick.
    while ((int'(div) % per) != (per / 2)) step();
    new_frame = 1'b1;
    i_data    = 22'h01a5c3;
    sb.push_back(22'h01a5c3);
    step();
    new_frame = 1'b0;
    check("no_pop_same_cycle_empty", {23'd0, UART_TX}, 24'd1);
    wait_pre_tick(1);
    step();
    check("start_next_tick", {23'd0, UART_TX}, 24'd0);
    wait_drain(31 * 32 + 200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
